// File: rtl/rom_loader_pkg.sv
// rtl/rom_loader_pkg.sv - shared state, record type and sizes for the ROM boot loader
//
// Purpose: common definitions imported by rom_loader and rom_record_asm.
// Ports: none (package).
package rom_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HEADER,
    ST_FETCH,
    ST_EMIT,
    ST_DONE
  } state_t;

  localparam int RECORD_BYTES = 9;
  localparam int HEADER_BYTES = 1;

  typedef struct packed {
    logic [7:0]  opcode;
    logic [31:0] op_a;
    logic [31:0] op_b;
  } record_t;

endpackage

// File: rtl/rom_record_asm.sv
// rtl/rom_record_asm.sv - assembles ROM bytes into 9-byte instruction records
//
// Purpose: byte shifter plus position counter k. Each strobe shifts one byte in;
//          after RECORD_BYTES strobes the record outputs hold opcode/op_a/op_b (LE).
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   clear        restart assembly at k=0
//   strobe       consume byte_in this cycle
//   byte_in      ROM byte
//   rec          assembled record (valid after the last_byte strobe)
//   last_byte    high while k is the final record position
module rom_record_asm
  import rom_loader_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       strobe,
  input  logic [7:0] byte_in,
  output record_t    rec,
  output logic       last_byte
);

  localparam int KW = $clog2(RECORD_BYTES);

  logic [RECORD_BYTES*8-1:0] shreg;
  logic [KW-1:0]             k;

  // Bytes enter at the top and move down, so after a full record the first
  // byte sits in [7:0] and each operand lands little-endian without reordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg <= '0;
      k     <= '0;
    end else if (clear) begin
      k <= '0;
    end else if (strobe) begin
      shreg <= {byte_in, shreg[RECORD_BYTES*8-1:8]};
      k     <= last_byte ? '0 : k + KW'(1);
    end
  end

  assign last_byte  = (k == KW'(RECORD_BYTES - 1));
  assign rec.opcode = shreg[7:0];
  assign rec.op_a   = shreg[39:8];
  assign rec.op_b   = shreg[71:40];

endmodule

// File: rtl/rom_loader.sv
// rtl/rom_loader.sv - boot-time sequencer walking the program ROM into instruction records
//
// Purpose: reads a 1-byte header then 9-byte records from a combinational ROM and
//          hands each record out over a valid/ready port.
// Optional feature: ROM_LOADER_CHECKSUM_EN adds checksum[7:0], the mod-256 sum of
//          every consumed byte (header included), cleared on start.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   start                      load request (honoured in IDLE or DONE)
//   rom_address/rom_byte       ROM byte address and its data (same cycle)
//   rom_done                   current address is the last image byte
//   header_byte                image header byte
//   instr_valid/instr_ready    record handshake
//   instr_opcode/op_a/op_b     record fields; instr_index = record number
//   busy/load_done/load_error  status levels
module rom_loader
  import rom_loader_pkg::*;
#(
  parameter int ADDR_LIMIT = 4096,
  parameter int INDEX_W    = 12
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic [31:0]        rom_address,
  input  logic [7:0]         rom_byte,
  input  logic               rom_done,
  output logic [7:0]         header_byte,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [7:0]         instr_opcode,
  output logic [31:0]        instr_op_a,
  output logic [31:0]        instr_op_b,
  output logic [INDEX_W-1:0] instr_index,
  output logic               busy,
  output logic               load_done,
  output logic               load_error
`ifdef ROM_LOADER_CHECKSUM_EN
  ,
  output logic [7:0]         checksum
`endif
);

  state_t             state, state_nx;
  logic [31:0]        addr_q;
  logic [7:0]         header_q;
  logic [INDEX_W-1:0] index_q;
  logic               err_q;
  logic               fin_q;      // record being emitted is the last one
  logic               fin_err_q;  // ... and it ended on the byte limit, not rom_done
  logic               restart, consume, fetch_stb, accept, abort, limit_hit;
  logic               last_byte;
  record_t            rec;

  // Consuming the byte at ADDR_LIMIT-1 brings the consumed count to ADDR_LIMIT.
  assign limit_hit = (addr_q == 32'(ADDR_LIMIT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    restart   = 1'b0;
    consume   = 1'b0;
    fetch_stb = 1'b0;
    accept    = 1'b0;
    abort     = 1'b0;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          restart  = 1'b1;
          state_nx = ST_HEADER;
        end
      end
      ST_HEADER: begin
        consume = 1'b1;
        if (rom_done || limit_hit) begin
          abort    = 1'b1;
          state_nx = ST_DONE;
        end else begin
          state_nx = ST_FETCH;
        end
      end
      ST_FETCH: begin
        consume   = 1'b1;
        fetch_stb = 1'b1;
        if (last_byte) begin
          state_nx = ST_EMIT;
        end else if (rom_done || limit_hit) begin
          abort    = 1'b1;
          state_nx = ST_DONE;
        end
      end
      ST_EMIT: begin
        if (instr_ready) begin
          accept   = 1'b1;
          state_nx = fin_q ? ST_DONE : ST_FETCH;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q    <= '0;
      header_q  <= '0;
      index_q   <= '0;
      err_q     <= 1'b0;
      fin_q     <= 1'b0;
      fin_err_q <= 1'b0;
    end else begin
      if (restart) begin
        addr_q    <= '0;
        index_q   <= '0;
        err_q     <= 1'b0;
        fin_q     <= 1'b0;
        fin_err_q <= 1'b0;
      end
      if (state == ST_HEADER) begin
        header_q <= rom_byte;
        addr_q   <= 32'(HEADER_BYTES);
      end else if (consume) begin
        addr_q <= addr_q + 32'd1;
      end
      if (abort) err_q <= 1'b1;
      // rom_done wins over the limit when both land on a record's final byte.
      if (fetch_stb && last_byte) begin
        fin_q     <= rom_done | limit_hit;
        fin_err_q <= limit_hit & ~rom_done;
      end
      if (accept) begin
        index_q <= index_q + INDEX_W'(1);
        if (fin_q) err_q <= fin_err_q;
      end
    end
  end

`ifdef ROM_LOADER_CHECKSUM_EN
  logic [7:0] sum_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       sum_q <= '0;
    else if (restart) sum_q <= '0;
    else if (consume) sum_q <= sum_q + rom_byte;
  end
  assign checksum = sum_q;
`endif

  rom_record_asm u_asm (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (restart),
    .strobe    (fetch_stb),
    .byte_in   (rom_byte),
    .rec       (rec),
    .last_byte (last_byte)
  );

  assign rom_address  = addr_q;
  assign header_byte  = header_q;
  assign instr_valid  = (state == ST_EMIT);
  assign instr_opcode = rec.opcode;
  assign instr_op_a   = rec.op_a;
  assign instr_op_b   = rec.op_b;
  assign instr_index  = index_q;
  assign busy         = (state == ST_HEADER) || (state == ST_FETCH) || (state == ST_EMIT);
  assign load_done    = (state == ST_DONE);
  assign load_error   = err_q;

endmodule
